regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of write data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, the width of the register index.

Ports:
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port ReqA_Valid, input, 1 bit: requester A (ALU writeback) has a write pending.
REQ-006 The block SHALL have port ReqA_Reg, input, ADDR_WIDTH bits: requester A destination register.
REQ-007 The block SHALL have port ReqA_Data, input, DATA_WIDTH bits: requester A write data.
REQ-008 The block SHALL have port ReqA_Ready, output, 1 bit: requester A write is accepted this cycle.
REQ-009 The block SHALL have ports ReqB_Valid, ReqB_Reg, ReqB_Data and ReqB_Ready for requester B (load writeback), with the same directions, widths and meanings as the A ports.
REQ-010 The block SHALL have port Flush, input, 1 bit: synchronous discard of all pending and accepted writes.
REQ-011 The block SHALL have port RegWrite, output, 1 bit: register-file write enable.
REQ-012 The block SHALL have port WriteRegister, output, ADDR_WIDTH bits: register-file write index.
REQ-013 The block SHALL have port WriteData, output, DATA_WIDTH bits: register-file write data.
REQ-014 The block SHALL have port GrantCountA, output, 8 bits: wrapping count of writes granted to A.
REQ-015 The block SHALL have port GrantCountB, output, 8 bits: wrapping count of writes granted to B.

Function
REQ-016 The block SHALL grant at most one requester per cycle; ReqX_Ready SHALL be combinational from Valid inputs, the priority pointer and Flush.
REQ-017 A transfer SHALL occur on a rising edge where ReqX_Valid=1 and ReqX_Ready=1; requesters hold Reg/Data stable while Valid=1 and Ready=0.
REQ-018 If exactly one requester is valid and Flush=0, that requester SHALL be granted.
REQ-019 If both requesters are valid, the one indicated by the priority pointer PRI (0=A, 1=B) SHALL be granted.
REQ-020 After any grant, PRI SHALL point to the non-granted requester; with no grant, PRI SHALL hold.
REQ-021 Under continuous dual requests, grants SHALL alternate A,B,A,B...; no requester waits more than 1 cycle.
REQ-022 On the edge of a transfer to a nonzero register, RegWrite SHALL become 1 and WriteRegister/WriteData SHALL take the granted Reg/Data; latency is 1 cycle from acceptance.
REQ-023 On the edge of a transfer to register 0, the write SHALL be accepted and counted, and RegWrite SHALL be 0 in the next cycle.
REQ-024 In cycles with no transfer, RegWrite SHALL be 0 and WriteRegister/WriteData SHALL hold their last values.
REQ-025 When both requesters target the same nonzero register, the writes SHALL reach the register file in grant order in consecutive cycles, with no merging.
REQ-026 While Flush=1, ReqA_Ready and ReqB_Ready SHALL be 0, RegWrite SHALL be 0 on the next edge, and PRI and the counts SHALL hold.
REQ-027 GrantCountX SHALL increment by 1 on each transfer of requester X and wrap from 255 to 0.

Reset
REQ-028 While Reset=1, regardless of Clk, RegWrite, WriteRegister, WriteData, GrantCountA and GrantCountB SHALL be 0, and PRI SHALL be 0 (A first).
REQ-029 While Reset=1, ReqA_Ready and ReqB_Ready SHALL be 0.
REQ-030 A transfer in progress at reset assertion SHALL be dropped, and no RegWrite pulse SHALL follow reset deassertion.

Verification
REQ-031 The bench SHALL cover: after reset, A valid alone with Reg=3, Data=0x11 -> ReqA_Ready=1 that cycle; next cycle RegWrite=1, WriteRegister=3, WriteData=0x11; GrantCountA=1.
REQ-032 The bench SHALL cover: A and B both valid for 4 cycles after reset -> grants A,B,A,B; GrantCountA=2, GrantCountB=2.
REQ-033 The bench SHALL cover: B valid alone with Reg=0, Data=0xFF -> ReqB_Ready=1; next cycle RegWrite=0; GrantCountB increments.
REQ-034 The bench SHALL cover: A and B both target Reg=7 (A=0x1, B=0x2) with PRI=A -> writes to 7 of 0x1 then 0x2 on consecutive cycles.
REQ-035 The bench SHALL cover: Flush=1 with both valid -> both Ready=0, RegWrite=0 next cycle, PRI and counts unchanged.
REQ-036 The bench SHALL cover: Reset asserted mid-cycle during a grant -> outputs 0 immediately; no RegWrite after deassertion; 256 A grants -> GrantCountA wraps to 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: round-robin grant between ALU (A)
// and load (B) writeback, one registered write port, per-requester grant counts.
module regfile_grant_counter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqA_Valid,
  input  logic [ADDR_WIDTH-1:0] ReqA_Reg,
  input  logic [DATA_WIDTH-1:0] ReqA_Data,
  output logic                  ReqA_Ready,
  input  logic                  ReqB_Valid,
  input  logic [ADDR_WIDTH-1:0] ReqB_Reg,
  input  logic [DATA_WIDTH-1:0] ReqB_Data,
  output logic                  ReqB_Ready,
  input  logic                  Flush,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [7:0]            GrantCountA,
  output logic [7:0]            GrantCountB
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t [NUM_REQ-1:0] req;
  wr_req_t               win;
  logic [NUM_REQ-1:0]    vld, rdy;
  logic [NUM_REQ-1:0][7:0] cnt;
  logic                  xfer, sel;

  logic                  pri_q, pri_d;
  logic                  regwrite_q, regwrite_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  assign vld    = {ReqB_Valid, ReqA_Valid};
  assign req[0] = '{rd: ReqA_Reg, data: ReqA_Data};
  assign req[1] = '{rd: ReqB_Reg, data: ReqB_Data};

  // Ready is gated by Reset too so nothing looks accepted while held in reset.
  always_comb begin
    rdy = '0;
    if (!Reset && !Flush) begin
      if (&vld) rdy[pri_q] = 1'b1;
      else      rdy        = vld;
    end
  end

  assign xfer = |rdy;
  assign sel  = rdy[1];
  assign win  = req[sel];

  always_comb begin
    pri_d      = pri_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (xfer) begin
      pri_d = ~sel;
      // Writes to register 0 are accepted and counted but never reach the file.
      if (win.rd != '0) begin
        regwrite_d = 1'b1;
        wreg_d     = win.rd;
        wdata_d    = win.data;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      pri_q      <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      pri_q      <= pri_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    regfile_grant_counter u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .inc_i (rdy[g]),
      .cnt_o (cnt[g])
    );
  end

  assign ReqA_Ready    = rdy[0];
  assign ReqB_Ready    = rdy[1];
  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign GrantCountA   = cnt[0];
  assign GrantCountB   = cnt[1];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench for regfile_write_arbiter against a behavioural
// model tracking priority, grant counts and the expected register-file write.
module tb_regfile_write_arbiter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqA_Valid, ReqB_Valid, Flush;
  logic [4:0]  ReqA_Reg, ReqB_Reg;
  logic [31:0] ReqA_Data, ReqB_Data;
  logic        ReqA_Ready, ReqB_Ready, RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [7:0]  GrantCountA, GrantCountB;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  bit          m_pri;
  int          m_cnt_a, m_cnt_b;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          ga, gb;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA_Valid(ReqA_Valid), .ReqA_Reg(ReqA_Reg), .ReqA_Data(ReqA_Data), .ReqA_Ready(ReqA_Ready),
    .ReqB_Valid(ReqB_Valid), .ReqB_Reg(ReqB_Reg), .ReqB_Data(ReqB_Data), .ReqB_Ready(ReqB_Ready),
    .Flush(Flush), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .GrantCountA(GrantCountA), .GrantCountB(GrantCountB)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_pri = 0; m_cnt_a = 0; m_cnt_b = 0; m_we = 0; m_reg = '0; m_data = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; ReqA_Valid = 0; ReqB_Valid = 0; Flush = 0;
    ReqA_Reg = '0; ReqB_Reg = '0; ReqA_Data = '0; ReqB_Data = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  // Drive a cycle's inputs and decide who the rules say wins it.
  task automatic apply(input bit va, input logic [4:0] ra, input logic [31:0] da,
                       input bit vb, input logic [4:0] rb, input logic [31:0] db,
                       input bit fl);
    ReqA_Valid = va; ReqA_Reg = ra; ReqA_Data = da;
    ReqB_Valid = vb; ReqB_Reg = rb; ReqB_Data = db; Flush = fl;
    ga = 0; gb = 0;
    if (!fl) begin
      if (va && vb) begin ga = (m_pri == 0); gb = (m_pri == 1); end
      else begin ga = va; gb = vb; end
    end
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    m_we = 0;
    if (ga) begin
      m_cnt_a = (m_cnt_a + 1) % 256; m_pri = 1;
      if (ReqA_Reg != 0) begin m_we = 1; m_reg = ReqA_Reg; m_data = ReqA_Data; end
    end
    if (gb) begin
      m_cnt_b = (m_cnt_b + 1) % 256; m_pri = 0;
      if (ReqB_Reg != 0) begin m_we = 1; m_reg = ReqB_Reg; m_data = ReqB_Data; end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; ReqA_Valid = 1; ReqB_Valid = 1; Flush = 0;
    ReqA_Reg = 5'd4; ReqB_Reg = 5'd6; ReqA_Data = 32'h5; ReqB_Data = 32'h6;
    @(posedge Clk); #1;
    n_cmp++; if ({RegWrite, WriteRegister, WriteData} !== '0) begin n_err++; $display("FAIL reset_wr got %b/%0d/%h want 0", RegWrite, WriteRegister, WriteData); end
    n_cmp++; if ({GrantCountA, GrantCountB} !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", GrantCountA, GrantCountB); end
    n_cmp++; if ({ReqA_Ready, ReqB_Ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b%b want 00", ReqA_Ready, ReqB_Ready); end
    do_reset();
  endtask

  task automatic test_single_a();
    apply(1, 5'd3, 32'h11, 0, 5'd0, 32'h0, 0);
    n_cmp++; if (ReqA_Ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready got %b want 1", ReqA_Ready); end
    tick();
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    n_cmp++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd3, 32'h11}) begin n_err++; $display("FAIL single_a_wr got %b/%0d/%h want 1/3/11", RegWrite, WriteRegister, WriteData); end
    n_cmp++; if (GrantCountA !== 8'd1) begin n_err++; $display("FAIL single_a_cnt got %0d want 1", GrantCountA); end
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL idle_we got %b want 0", RegWrite); end
    n_cmp++; if ({WriteRegister, WriteData} !== {5'd3, 32'h11}) begin n_err++; $display("FAIL idle_hold got %0d/%h want 3/11", WriteRegister, WriteData); end
  endtask

  task automatic test_alternate();
    bit exp_a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 5'd1, 32'hA0 + i, 1, 5'd2, 32'hB0 + i, 0);
      exp_a = (i % 2 == 0);
      n_cmp++; if ({ReqA_Ready, ReqB_Ready} !== {exp_a, !exp_a}) begin n_err++; $display("FAIL alt_grant%0d got %b%b want %b%b", i, ReqA_Ready, ReqB_Ready, exp_a, !exp_a); end
      tick();
      n_cmp++; if ({RegWrite, WriteRegister} !== {1'b1, exp_a ? 5'd1 : 5'd2}) begin n_err++; $display("FAIL alt_wr%0d got %b/%0d want 1/%0d", i, RegWrite, WriteRegister, exp_a ? 1 : 2); end
    end
    n_cmp++; if ({GrantCountA, GrantCountB} !== {8'd2, 8'd2}) begin n_err++; $display("FAIL alt_cnt got %0d/%0d want 2/2", GrantCountA, GrantCountB); end
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_reg0();
    int cb;
    cb = GrantCountB;
    apply(0, 5'd0, 32'h0, 1, 5'd0, 32'hFF, 0);
    n_cmp++; if (ReqB_Ready !== 1'b1) begin n_err++; $display("FAIL reg0_ready got %b want 1", ReqB_Ready); end
    tick();
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reg0_we got %b want 0", RegWrite); end
    n_cmp++; if (GrantCountB !== 8'((cb + 1) % 256)) begin n_err++; $display("FAIL reg0_cnt got %0d want %0d", GrantCountB, (cb + 1) % 256); end
  endtask

  task automatic test_same_reg();
    do_reset();
    apply(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0);
    n_cmp++; if ({ReqA_Ready, ReqB_Ready} !== 2'b10) begin n_err++; $display("FAIL same_g1 got %b%b want 10", ReqA_Ready, ReqB_Ready); end
    tick();
    apply(0, 5'd0, 32'h0, 1, 5'd7, 32'h2, 0);
    n_cmp++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd7, 32'h1}) begin n_err++; $display("FAIL same_w1 got %b/%0d/%h want 1/7/1", RegWrite, WriteRegister, WriteData); end
    n_cmp++; if (ReqB_Ready !== 1'b1) begin n_err++; $display("FAIL same_g2 got %b want 1", ReqB_Ready); end
    tick();
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    n_cmp++; if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd7, 32'h2}) begin n_err++; $display("FAIL same_w2 got %b/%0d/%h want 1/7/2", RegWrite, WriteRegister, WriteData); end
  endtask

  task automatic test_flush();
    logic [7:0] ca, cb;
    bit pri0;
    // Leave PRI pointing at B so that "PRI unchanged" is observable.
    apply(1, 5'd9, 32'h9, 0, 5'd0, 32'h0, 0);
    tick();
    ca = GrantCountA; cb = GrantCountB; pri0 = m_pri;
    apply(1, 5'd10, 32'hA, 1, 5'd11, 32'hB, 1);
    n_cmp++; if ({ReqA_Ready, ReqB_Ready} !== 2'b00) begin n_err++; $display("FAIL flush_ready got %b%b want 00", ReqA_Ready, ReqB_Ready); end
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL flush_we got %b want 0", RegWrite); end
    n_cmp++; if ({GrantCountA, GrantCountB} !== {ca, cb}) begin n_err++; $display("FAIL flush_cnt got %0d/%0d want %0d/%0d", GrantCountA, GrantCountB, ca, cb); end
    apply(1, 5'd10, 32'hA, 1, 5'd11, 32'hB, 0);
    n_cmp++; if ({ReqA_Ready, ReqB_Ready} !== {pri0 == 0, pri0 == 1}) begin n_err++; $display("FAIL flush_pri got %b%b want B first", ReqA_Ready, ReqB_Ready); end
    tick();
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    apply(1, 5'd12, 32'hC, 0, 5'd0, 32'h0, 0);
    tick();
    apply(1, 5'd13, 32'hD, 0, 5'd0, 32'h0, 0);
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if ({RegWrite, WriteRegister, WriteData, GrantCountA, GrantCountB} !== '0) begin n_err++; $display("FAIL midrst_out got %b/%0d/%h/%0d/%0d want 0", RegWrite, WriteRegister, WriteData, GrantCountA, GrantCountB); end
    n_cmp++; if (ReqA_Ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0", ReqA_Ready); end
    @(posedge Clk); @(negedge Clk);
    ReqA_Valid = 0;
    Reset = 1'b0;
    model_reset();
    ga = 0; gb = 0;
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL midrst_nowe got %b want 0", RegWrite); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      apply(1, 5'(i), 32'(i), 0, 5'd0, 32'h0, 0);
      tick();
      if (i == 254) begin
        n_cmp++; if (GrantCountA !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d want 255", GrantCountA); end
      end
    end
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    n_cmp++; if (GrantCountA !== 8'd0) begin n_err++; $display("FAIL wrap_0 got %0d want 0", GrantCountA); end
  endtask

  task automatic test_random();
    bit pa = 0, pb = 0, fl;
    logic [4:0] ra = '0, rb = '0;
    logic [31:0] da = '0, db = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin pa = 1; ra = 5'($urandom); da = $urandom; end
      if (!pb && $urandom_range(0, 2) != 0) begin pb = 1; rb = 5'($urandom); db = $urandom; end
      fl = ($urandom_range(0, 7) == 0);
      apply(pa, ra, da, pb, rb, db, fl);
      n_cmp++; if ({ReqA_Ready, ReqB_Ready} !== {ga, gb}) begin n_err++; $display("FAIL rnd_ready c%0d got %b%b want %b%b", c, ReqA_Ready, ReqB_Ready, ga, gb); end
      tick();
      if (ga) pa = 0;
      if (gb) pb = 0;
      n_cmp++; if (RegWrite !== m_we) begin n_err++; $display("FAIL rnd_we c%0d got %b want %b", c, RegWrite, m_we); end
      if (m_we) begin
        n_cmp++; if ({WriteRegister, WriteData} !== {m_reg, m_data}) begin n_err++; $display("FAIL rnd_wr c%0d got %0d/%h want %0d/%h", c, WriteRegister, WriteData, m_reg, m_data); end
      end
      n_cmp++; if ({GrantCountA, GrantCountB} !== {8'(m_cnt_a), 8'(m_cnt_b)}) begin n_err++; $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", c, GrantCountA, GrantCountB, m_cnt_a, m_cnt_b); end
    end
    apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_alternate();
    test_reg0();
    test_same_reg();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
